oram_path_ctrl: RTL and testbench

Parametrised, synthesizable Path ORAM controller for the ORAM core. It serves one oblivious read or write per request by:
- reading the whole root-to-leaf path into a stash,
- remapping the block to a fresh random leaf,
- writing the path back greedily from leaf to root.

Unlike the behavioural single-shot ORAM module, it has a real multi-cycle FSM with a busy/done handshake, configurable tree shape, an LFSR leaf source, and stash-overflow reporting.

---
 rtl/oram_path_ctrl_if.sv | 25 ++
 rtl/oram_path_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_oram_path_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_path_ctrl_if.sv
// Request/response bundle between an ORAM client and oram_path_ctrl.
// The client drives a request; the controller returns busy, read data and status.
interface oram_path_if #(
  parameter int D = 4,
  parameter int A = 4
);
  logic [D-1:0]   rw_block_number;
  logic [8*A-1:0] w_value;
  logic           rw_indicator;
  logic           input_ready;
  logic           busy;
  logic [8*A-1:0] r_value;
  logic           output_ready;
  logic           stash_overflow;

  modport master (
    output rw_block_number, w_value, rw_indicator, input_ready,
    input  busy, r_value, output_ready, stash_overflow
  );

  modport slave (
    input  rw_block_number, w_value, rw_indicator, input_ready,
    output busy, r_value, output_ready, stash_overflow
  );
endinterface

// File: rtl/oram_path_ctrl.sv
// Path ORAM controller: reads a root-to-leaf path into a stash, remaps the
// block to an LFSR leaf and greedily writes the path back from leaf to root.
module oram_path_ctrl #(
  parameter int          D         = 4,
  parameter int          L         = 3,
  parameter int          Z         = 2,
  parameter int          A         = 4,
  parameter int          S         = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic       clk,
  input logic       rst,
  oram_path_if.slave bus
);

  localparam int NB   = (1 << (L + 1)) - 1;
  localparam int NS   = NB * Z;
  localparam int TW   = $clog2(NS);
  localparam int SW   = (S > 1) ? $clog2(S) : 1;
  localparam int ZW   = (Z > 1) ? $clog2(Z) : 1;
  localparam int LVW  = $clog2(L + 1);
  localparam int DW   = 8 * A;
  localparam int NBLK = 1 << D;

  // state  | meaning
  // IDLE   | waiting for input_ready
  // LOOKUP | fetch old leaf, store new leaf in position map
  // READ   | move valid path slots into stash, root to leaf
  // UPDATE | serve the request from the stash
  // WRITE  | refill path slots from stash, leaf to root
  // DONE   | completion, output_ready follows
  typedef enum logic [2:0] {IDLE, LOOKUP, READ, UPDATE, WRITE, DONE} state_t;

  state_t          state_q;
  logic [LVW-1:0]  lvl_q;
  logic [ZW-1:0]   slot_q;
  logic [D-1:0]    addr_q;
  logic            op_q;
  logic [DW-1:0]   wdata_q;
  logic [L-1:0]    p_q;
  logic [L-1:0]    n_q;
  logic [15:0]     lfsr_q;
  logic            busy_q;
  logic            ordy_q;
  logic [DW-1:0]   rdata_q;
  logic            ovf_q;

  logic            t_valid_q [NS];
  logic [D-1:0]    t_addr_q  [NS];
  logic [L-1:0]    t_leaf_q  [NS];
  logic [DW-1:0]   t_data_q  [NS];
  logic            s_valid_q [S];
  logic [D-1:0]    s_addr_q  [S];
  logic [L-1:0]    s_leaf_q  [S];
  logic [DW-1:0]   s_data_q  [S];
  logic [L-1:0]    pos_q     [NBLK];

  logic [15:0]     lfsr_d;
  logic [TW-1:0]   slot_idx;
  int              sh;
  logic            free_ok, hit_ok, elig_ok;
  logic [SW-1:0]   free_idx, hit_idx, elig_idx;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Heap-ordered buckets: level l of path p is node (2^l - 1) + (p >> (L-l)).
  always_comb begin
    sh       = L - int'(lvl_q);
    slot_idx = TW'((((1 << int'(lvl_q)) - 1) + (int'(p_q) >> sh)) * Z + int'(slot_q));
    free_ok  = 1'b0;
    free_idx = '0;
    hit_ok   = 1'b0;
    hit_idx  = '0;
    elig_ok  = 1'b0;
    elig_idx = '0;
    for (int i = S - 1; i >= 0; i--) begin
      if (!s_valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = SW'(i);
      end
      if (s_valid_q[i] && (s_addr_q[i] == addr_q)) begin
        hit_ok  = 1'b1;
        hit_idx = SW'(i);
      end
      if (s_valid_q[i] && ((int'(s_leaf_q[i]) >> sh) == (int'(p_q) >> sh))) begin
        elig_ok  = 1'b1;
        elig_idx = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      slot_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      p_q     <= '0;
      n_q     <= '0;
      lfsr_q  <= LFSR_SEED;
      busy_q  <= 1'b0;
      ordy_q  <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NS; i++) t_valid_q[i] <= 1'b0;
      for (int i = 0; i < S; i++) s_valid_q[i] <= 1'b0;
      for (int i = 0; i < NBLK; i++) pos_q[i] <= L'(i);
    end else begin
      busy_q <= (state_q != IDLE);
      ordy_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.input_ready) begin
            addr_q  <= bus.rw_block_number;
            op_q    <= bus.rw_indicator;
            wdata_q <= bus.w_value;
            lfsr_q  <= lfsr_d;
            n_q     <= lfsr_d[L-1:0];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          p_q           <= pos_q[addr_q];
          pos_q[addr_q] <= n_q;
          lvl_q         <= '0;
          slot_q        <= '0;
          state_q       <= READ;
        end
        READ: begin
          if (t_valid_q[slot_idx]) begin
            t_valid_q[slot_idx] <= 1'b0;
            if (free_ok) begin
              s_valid_q[free_idx] <= 1'b1;
              s_addr_q[free_idx]  <= t_addr_q[slot_idx];
              s_leaf_q[free_idx]  <= t_leaf_q[slot_idx];
              s_data_q[free_idx]  <= t_data_q[slot_idx];
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (slot_q == ZW'(Z - 1)) begin
            slot_q <= '0;
            if (lvl_q == LVW'(L)) state_q <= UPDATE;
            else                  lvl_q   <= lvl_q + 1'b1;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        UPDATE: begin
          if (hit_ok) begin
            s_leaf_q[hit_idx] <= n_q;
            if (op_q) s_data_q[hit_idx] <= wdata_q;
            else      rdata_q           <= s_data_q[hit_idx];
          end else begin
            if (!op_q) rdata_q <= '0;
            if (free_ok) begin
              s_valid_q[free_idx] <= 1'b1;
              s_addr_q[free_idx]  <= addr_q;
              s_leaf_q[free_idx]  <= n_q;
              s_data_q[free_idx]  <= op_q ? wdata_q : '0;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          lvl_q   <= LVW'(L);
          slot_q  <= '0;
          state_q <= WRITE;
        end
        WRITE: begin
          if (elig_ok) begin
            t_valid_q[slot_idx] <= 1'b1;
            t_addr_q[slot_idx]  <= s_addr_q[elig_idx];
            t_leaf_q[slot_idx]  <= s_leaf_q[elig_idx];
            t_data_q[slot_idx]  <= s_data_q[elig_idx];
            s_valid_q[elig_idx] <= 1'b0;
          end else begin
            t_valid_q[slot_idx] <= 1'b0;
          end
          if (slot_q == ZW'(Z - 1)) begin
            slot_q <= '0;
            if (lvl_q == '0) state_q <= DONE;
            else             lvl_q   <= lvl_q - 1'b1;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.output_ready   = ordy_q;
  assign bus.r_value        = rdata_q;
  assign bus.stash_overflow = ovf_q;

endmodule

// File: tb/tb_oram_path_ctrl.sv
// Scoreboard bench for oram_path_ctrl: a reference model of the LFSR, position
// map and block contents supplies expected read data and tree/stash placement.
module tb_oram_path_ctrl;
  localparam int D  = 4;
  localparam int L  = 2;
  localparam int Z  = 2;
  localparam int A  = 4;
  localparam int S  = 16;
  localparam int NS = ((1 << (L + 1)) - 1) * Z;
  localparam int LAT = 2 * (L + 1) * Z + 3;

  logic clk = 1'b0;
  logic rst;
  logic rst_ovf;
  always #5 clk = ~clk;

  oram_path_if #(.D(D), .A(A)) bus ();
  oram_path_if #(.D(4), .A(4)) obus ();

  oram_path_ctrl #(.D(D), .L(L), .Z(Z), .A(A), .S(S), .LFSR_SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  oram_path_ctrl #(.D(4), .L(1), .Z(4), .A(4), .S(2), .LFSR_SEED(16'hACE1)) u_ovf (
    .clk(clk), .rst(rst_ovf), .bus(obus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] m_lfsr;
  logic [L-1:0] m_pos [16];
  logic [31:0] m_mem  [16];
  bit          m_touch[16];

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      m_pos[i]   = L'(i);
      m_mem[i]   = 32'h0;
      m_touch[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_accept(input logic w, input logic [3:0] a, input logic [31:0] v);
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_pos[a]   = m_lfsr[L-1:0];
    m_touch[a] = 1'b1;
    if (w) m_mem[a] = v;
    else   exp_q.push_back(m_mem[a]);
  endtask

  // Issues one request once the controller is idle; returns edges from acceptance to output_ready.
  task automatic do_op(input logic w, input logic [3:0] a, input logic [31:0] v, output int lat);
    int t;
    t = 0;
    while (bus.busy !== 1'b0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(negedge clk);
    bus.rw_indicator = w; bus.rw_block_number = a; bus.w_value = v; bus.input_ready = 1'b1;
    @(posedge clk);
    model_accept(w, a, v);
    #1 bus.input_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (bus.output_ready !== 1'b1 && lat < 200);
    if (bus.output_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL op_timeout block=%0d: no output_ready within %0d cycles", a, lat);
      lat = -1;
    end
  endtask

  task automatic ovf_op(input logic w, input logic [3:0] a, input logic [31:0] v);
    int t;
    t = 0;
    while (obus.busy !== 1'b0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(negedge clk);
    obus.rw_indicator = w; obus.rw_block_number = a; obus.w_value = v; obus.input_ready = 1'b1;
    @(posedge clk); #1 obus.input_ready = 1'b0;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (obus.output_ready !== 1'b1 && t < 200);
    if (obus.output_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ovf_op_timeout block=%0d", a);
    end
  endtask

  // Counts placement violations: wrong leaf, off-path bucket, wrong data, missing or duplicated block.
  function automatic int inv_errors();
    int e, a, node, lv;
    int cnt[16];
    e = 0;
    for (int b = 0; b < 16; b++) cnt[b] = 0;
    for (int s = 0; s < NS; s++) begin
      if (u_dut.t_valid_q[s]) begin
        a = int'(u_dut.t_addr_q[s]);
        cnt[a]++;
        node = s / Z;
        lv = 0;
        while (((1 << (lv + 1)) - 1) <= node) lv++;
        if (u_dut.t_leaf_q[s] !== m_pos[a]) e++;
        if ((node - ((1 << lv) - 1)) != (int'(m_pos[a]) >> (L - lv))) e++;
        if (m_touch[a] && u_dut.t_data_q[s] !== m_mem[a]) e++;
      end
    end
    for (int s = 0; s < S; s++) begin
      if (u_dut.s_valid_q[s]) begin
        a = int'(u_dut.s_addr_q[s]);
        cnt[a]++;
        if (u_dut.s_leaf_q[s] !== m_pos[a]) e++;
        if (m_touch[a] && u_dut.s_data_q[s] !== m_mem[a]) e++;
      end
    end
    for (int b = 0; b < 16; b++)
      if (cnt[b] > 1 || (m_touch[b] && cnt[b] != 1)) e++;
    return e;
  endfunction

  task automatic test_reset();
    int lat, e;
    logic [31:0] x;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ordy got=%b exp=0", bus.output_ready); end
    n_checks++; if (bus.r_value !== 32'h0) begin n_fail++; $display("FAIL reset_rvalue got=%h exp=0", bus.r_value); end
    n_checks++; if (bus.stash_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.stash_overflow); end
    @(negedge clk) rst = 1'b1;
    model_reset();
    do_op(1'b0, 4'd3, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL reset_read3 got=%h exp=%h", bus.r_value, x); end
    e = inv_errors();
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL reset_invariant got=%0d violations exp=0", e); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] x;
    do_op(1'b1, 4'd5, 32'hDEADBEEF, lat);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL latency got=%0d exp=%0d", lat, LAT); end
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got=%b exp=0", bus.busy); end
    n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL ordy_one_cycle got=%b exp=0", bus.output_ready); end
    do_op(1'b0, 4'd5, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL read5 got=%h exp=%h", bus.r_value, x); end
  endtask

  task automatic test_overwrite();
    int lat;
    logic [31:0] x;
    do_op(1'b1, 4'd2, 32'h1, lat);
    do_op(1'b1, 4'd2, 32'h2, lat);
    do_op(1'b0, 4'd2, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL overwrite got=%h exp=%h", bus.r_value, x); end
    n_checks++; if (bus.stash_overflow !== 1'b0) begin n_fail++; $display("FAIL overwrite_ovf got=%b exp=0", bus.stash_overflow); end
  endtask

  task automatic test_sweep();
    int lat, e;
    logic [31:0] x;
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 4'(i), 32'h1000 + i, lat);
      e = inv_errors();
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL sweep_wr_inv blk=%0d got=%0d violations exp=0", i, e); end
    end
    for (int i = 15; i >= 0; i--) begin
      do_op(1'b0, 4'(i), 32'h0, lat);
      x = exp_q.pop_front();
      n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL sweep_rd blk=%0d got=%h exp=%h", i, bus.r_value, x); end
      e = inv_errors();
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL sweep_rd_inv blk=%0d got=%0d violations exp=0", i, e); end
    end
    n_checks++; if (bus.stash_overflow !== 1'b0) begin n_fail++; $display("FAIL sweep_ovf got=%b exp=0", bus.stash_overflow); end
  endtask

  task automatic test_busy_ignored();
    int lat, pulses;
    logic [31:0] x;
    @(negedge clk);
    bus.rw_indicator = 1'b1; bus.rw_block_number = 4'd7; bus.w_value = 32'h7777; bus.input_ready = 1'b1;
    @(posedge clk);
    model_accept(1'b1, 4'd7, 32'h7777);
    #1 bus.input_ready = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.input_ready = (c == 3 || c == 8);
      bus.rw_block_number = 4'd8; bus.w_value = 32'hBAD0BAD0;
      @(posedge clk); #1;
      if (bus.output_ready === 1'b1) pulses++;
    end
    @(negedge clk) bus.input_ready = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    do_op(1'b0, 4'd8, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL busy_ignored_blk8 got=%h exp=%h", bus.r_value, x); end
    do_op(1'b0, 4'd7, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL busy_accepted_blk7 got=%h exp=%h", bus.r_value, x); end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [31:0] x;
    @(negedge clk);
    bus.rw_indicator = 1'b1; bus.rw_block_number = 4'd9; bus.w_value = 32'hCAFEF00D; bus.input_ready = 1'b1;
    @(posedge clk);
    #1 bus.input_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ordy got=%b exp=0", bus.output_ready); end
    n_checks++; if (bus.r_value !== 32'h0) begin n_fail++; $display("FAIL midrst_rvalue got=%h exp=0", bus.r_value); end
    @(negedge clk) rst = 1'b1;
    model_reset();
    do_op(1'b0, 4'd9, 32'h0, lat);
    x = exp_q.pop_front();
    n_checks++; if (bus.r_value !== x) begin n_fail++; $display("FAIL midrst_read9 got=%h exp=%h", bus.r_value, x); end
  endtask

  task automatic test_overflow();
    @(negedge clk) rst_ovf = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (obus.stash_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_initial got=%b exp=0", obus.stash_overflow); end
    for (int i = 0; i < 8; i++) ovf_op(1'b1, 4'(i), 32'h2000 + i);
    n_checks++; if (obus.stash_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_raised got=%b exp=1", obus.stash_overflow); end
    ovf_op(1'b0, 4'd0, 32'h0);
    ovf_op(1'b1, 4'd9, 32'h9);
    n_checks++; if (obus.stash_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", obus.stash_overflow); end
    @(negedge clk) rst_ovf = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (obus.stash_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got=%b exp=0", obus.stash_overflow); end
  endtask

  initial begin
    rst = 1'b0; rst_ovf = 1'b0;
    bus.input_ready = 1'b0; bus.rw_indicator = 1'b0; bus.rw_block_number = '0; bus.w_value = '0;
    obus.input_ready = 1'b0; obus.rw_indicator = 1'b0; obus.rw_block_number = '0; obus.w_value = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_overwrite();
    test_sweep();
    test_busy_ignored();
    test_mid_reset();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
